// File: rtl/fpaddsub_arbiter_if.sv
// Bundle of every non-clock signal around fpaddsub_arbiter.
//   slave  : arbiter view (takes requests and datapath results, drives grants,
//            responses and issued operands)
//   master : environment view (requesters, response consumers, FP datapath)
// Per requester n in {0,1}:
//   reqn_valid/reqn_ready, reqn_a, reqn_b (IEEE-754 single), reqn_ctrl (0 add, 1 sub)
//   rspn_valid/rspn_ready, rspn_z, rspn_flags {OF, UF, DZ, NV, NX}
// Datapath side: fp_valid, fp_a, fp_b, fp_ctrl out; fp_z, fp_flags back.
// Optional (FPADD_ARB_STICKY_FLAGS_EN): stickyn_flags out, stickyn_clr in.
interface fpaddsub_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req0_ctrl;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        req1_ctrl;

  logic        rsp0_valid;
  logic        rsp0_ready;
  logic [31:0] rsp0_z;
  logic [4:0]  rsp0_flags;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [31:0] rsp1_z;
  logic [4:0]  rsp1_flags;

  logic        fp_valid;
  logic [31:0] fp_a;
  logic [31:0] fp_b;
  logic        fp_ctrl;
  logic [31:0] fp_z;
  logic [4:0]  fp_flags;

`ifdef FPADD_ARB_STICKY_FLAGS_EN
  logic [4:0]  sticky0_flags;
  logic [4:0]  sticky1_flags;
  logic        sticky0_clr;
  logic        sticky1_clr;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctrl,
    input  req1_valid, req1_a, req1_b, req1_ctrl,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_z, rsp0_flags, rsp1_valid, rsp1_z, rsp1_flags,
    input  rsp0_ready, rsp1_ready,
    output fp_valid, fp_a, fp_b, fp_ctrl,
    input  fp_z, fp_flags,
    output sticky0_flags, sticky1_flags,
    input  sticky0_clr, sticky1_clr
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctrl,
    output req1_valid, req1_a, req1_b, req1_ctrl,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_z, rsp0_flags, rsp1_valid, rsp1_z, rsp1_flags,
    output rsp0_ready, rsp1_ready,
    input  fp_valid, fp_a, fp_b, fp_ctrl,
    output fp_z, fp_flags,
    input  sticky0_flags, sticky1_flags,
    output sticky0_clr, sticky1_clr
  );
`else
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctrl,
    input  req1_valid, req1_a, req1_b, req1_ctrl,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_z, rsp0_flags, rsp1_valid, rsp1_z, rsp1_flags,
    input  rsp0_ready, rsp1_ready,
    output fp_valid, fp_a, fp_b, fp_ctrl,
    input  fp_z, fp_flags
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctrl,
    output req1_valid, req1_a, req1_b, req1_ctrl,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_z, rsp0_flags, rsp1_valid, rsp1_z, rsp1_flags,
    output rsp0_ready, rsp1_ready,
    input  fp_valid, fp_a, fp_b, fp_ctrl,
    output fp_z, fp_flags
  );
`endif
endinterface

// File: rtl/fpaddsub_arbiter.sv
// Two-requester round-robin arbiter in front of a shared fixed-latency FP
// add/sub pipeline, with a per-requester result FIFO and credit-based issue.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : fpaddsub_arbiter_if.slave (request, response and datapath signals)
// Parameters:
//   PIPE_LAT   : issue-to-result latency of the datapath (1..8)
//   FIFO_DEPTH : result FIFO depth per requester (power of two, 2..16)
// Optional feature macro: FPADD_ARB_STICKY_FLAGS_EN adds per-requester
// accumulated flag registers with a clear input.
module fpaddsub_arbiter #(
  parameter int unsigned PIPE_LAT   = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  fpaddsub_arbiter_if.slave bus
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [31:0] z;
    logic [4:0]  flags;
  } rspEntryT;

  typedef struct packed {
    logic valid;
    logic tag;
  } tagEntryT;

  // Per-port views of the interface signals
  logic            reqValid [2];
  logic [31:0]     reqA     [2];
  logic [31:0]     reqB     [2];
  logic            reqCtrl  [2];
  logic            rspReady [2];
  logic            rspValid [2];
  rspEntryT        rspHead  [2];
  logic [CntW-1:0] credit   [2];

  assign reqValid[0] = bus.req0_valid;
  assign reqValid[1] = bus.req1_valid;
  assign reqA[0]     = bus.req0_a;
  assign reqA[1]     = bus.req1_a;
  assign reqB[0]     = bus.req0_b;
  assign reqB[1]     = bus.req1_b;
  assign reqCtrl[0]  = bus.req0_ctrl;
  assign reqCtrl[1]  = bus.req1_ctrl;
  assign rspReady[0] = bus.rsp0_ready;
  assign rspReady[1] = bus.rsp1_ready;

  assign bus.rsp0_valid = rspValid[0];
  assign bus.rsp0_z     = rspHead[0].z;
  assign bus.rsp0_flags = rspHead[0].flags;
  assign bus.rsp1_valid = rspValid[1];
  assign bus.rsp1_z     = rspHead[1].z;
  assign bus.rsp1_flags = rspHead[1].flags;

  logic       prioPtr;
  logic [1:0] eligible;
  logic [1:0] grant;
  logic       anyGrant;
  logic       grantIdx;

  // Eligibility and grant; the favoured requester (prioPtr) wins a tie
  always_comb begin
    eligible = '0;
    grant    = '0;
    for (int p = 0; p < 2; p++) begin
      eligible[p] = reqValid[p] && (credit[p] < CntW'(FIFO_DEPTH));
    end
    if (!rst) begin
      if (eligible == 2'b11) begin
        grant[prioPtr] = 1'b1;
      end else begin
        grant = eligible;
      end
    end
  end

  assign anyGrant       = |grant;
  assign grantIdx       = grant[1];
  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];

  // Issued operands are zeroed when nothing is granted
  always_comb begin
    bus.fp_valid = anyGrant;
    bus.fp_a     = '0;
    bus.fp_b     = '0;
    bus.fp_ctrl  = 1'b0;
    if (anyGrant) begin
      bus.fp_a    = reqA[grantIdx];
      bus.fp_b    = reqB[grantIdx];
      bus.fp_ctrl = reqCtrl[grantIdx];
    end
  end

  // Pointer only moves on contended grants
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prioPtr <= 1'b0;
    end else if (eligible == 2'b11) begin
      prioPtr <= ~prioPtr;
    end
  end

  // Tag pipeline shadowing the datapath latency
  tagEntryT tagPipe [PIPE_LAT];
  tagEntryT tagExit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        tagPipe[i] <= '0;
      end
    end else begin
      tagPipe[0].valid <= anyGrant;
      tagPipe[0].tag   <= grantIdx;
      for (int i = 1; i < PIPE_LAT; i++) begin
        tagPipe[i] <= tagPipe[i-1];
      end
    end
  end

  assign tagExit = tagPipe[PIPE_LAT-1];

`ifdef FPADD_ARB_STICKY_FLAGS_EN
  logic       stickyClr   [2];
  logic [4:0] stickyFlags [2];

  assign stickyClr[0]      = bus.sticky0_clr;
  assign stickyClr[1]      = bus.sticky1_clr;
  assign bus.sticky0_flags = stickyFlags[0];
  assign bus.sticky1_flags = stickyFlags[1];
`endif

  for (genvar p = 0; p < 2; p++) begin : gPort
    rspEntryT        mem [FIFO_DEPTH];
    logic [PtrW-1:0] wrPtr;
    logic [PtrW-1:0] rdPtr;
    logic [CntW-1:0] occQ;
    logic [CntW-1:0] creditQ;
    logic            push;
    logic            pop;

    assign push        = tagExit.valid && (tagExit.tag == 1'(p));
    assign pop         = rspValid[p] && rspReady[p];
    assign rspValid[p] = (occQ != '0);
    assign rspHead[p]  = mem[rdPtr];
    assign credit[p]   = creditQ;

    // FIFO pointers and occupancy; push and pop may coincide
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wrPtr <= '0;
        rdPtr <= '0;
        occQ  <= '0;
      end else begin
        if (push) wrPtr <= wrPtr + PtrW'(1);
        if (pop)  rdPtr <= rdPtr + PtrW'(1);
        if (push && !pop) begin
          occQ <= occQ + CntW'(1);
        end else if (pop && !push) begin
          occQ <= occQ - CntW'(1);
        end
      end
    end

    // Result storage is not reset; occupancy gates visibility
    always_ff @(posedge clk) begin
      if (push) begin
        mem[wrPtr] <= '{z: bus.fp_z, flags: bus.fp_flags};
      end
    end

    // Credit = in-flight ops for this port + FIFO occupancy
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        creditQ <= '0;
      end else if (grant[p] && !pop) begin
        creditQ <= creditQ + CntW'(1);
      end else if (pop && !grant[p]) begin
        creditQ <= creditQ - CntW'(1);
      end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
      if (!rst) begin
        assert (!(push && (occQ == CntW'(FIFO_DEPTH))))
          else $error("result fifo %0d written while full", p);
      end
    end
`endif

`ifdef FPADD_ARB_STICKY_FLAGS_EN
    logic [4:0] stickyQ;

    // A clear coinciding with a write keeps only the new flags
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stickyQ <= '0;
      end else if (push) begin
        stickyQ <= stickyClr[p] ? bus.fp_flags : (stickyQ | bus.fp_flags);
      end else if (stickyClr[p]) begin
        stickyQ <= '0;
      end
    end

    assign stickyFlags[p] = stickyQ;
`endif
  end

endmodule

// File: tb/tb_fpaddsub_arbiter.sv
// Directed bench for fpaddsub_arbiter with a stub FP datapath and a per-port
// response scoreboard. Define FPADD_ARB_STICKY_FLAGS_EN to include the
// sticky-flag steps.
module tb_fpaddsub_arbiter;
  localparam int unsigned PIPE_LAT   = 4;
  localparam int unsigned FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic rst;

  fpaddsub_arbiter_if bus ();

  fpaddsub_arbiter #(
    .PIPE_LAT   (PIPE_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] z;
    logic [4:0]  flags;
  } resT;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
  } dpOpT;

  resT sb0[$];
  resT sb1[$];

  // Stub datapath: integer add/sub, plus one real FP vector (1.0 + 2.0)
  function automatic logic [31:0] stubZ(input logic [31:0] a, input logic [31:0] b, input logic c);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000 && !c) return 32'h4040_0000;
    return c ? (a - b) : (a + b);
  endfunction

  function automatic logic [4:0] stubFlags(input logic [31:0] a, input logic [31:0] b);
    return a[4:0] ^ b[4:0];
  endfunction

  // Stub datapath is never reset, so stale results keep arriving after rst
  dpOpT dp [PIPE_LAT];
  always @(posedge clk) begin
    dp[0] <= '{a: bus.fp_a, b: bus.fp_b, c: bus.fp_ctrl};
    for (int i = 1; i < PIPE_LAT; i++) dp[i] <= dp[i-1];
  end
  assign bus.fp_z     = stubZ(dp[PIPE_LAT-1].a, dp[PIPE_LAT-1].b, dp[PIPE_LAT-1].c);
  assign bus.fp_flags = stubFlags(dp[PIPE_LAT-1].a, dp[PIPE_LAT-1].b);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on accepted request, pop/compare on consumed response
  always @(negedge clk) begin
    resT e;
    if (bus.req0_valid && bus.req0_ready)
      sb0.push_back('{z: stubZ(bus.req0_a, bus.req0_b, bus.req0_ctrl), flags: stubFlags(bus.req0_a, bus.req0_b)});
    if (bus.req1_valid && bus.req1_ready)
      sb1.push_back('{z: stubZ(bus.req1_a, bus.req1_b, bus.req1_ctrl), flags: stubFlags(bus.req1_a, bus.req1_b)});
    if (bus.rsp0_valid && bus.rsp0_ready) begin
      if (sb0.size() == 0) check("rsp0_unexpected", 64'd1, 64'd0);
      else begin
        e = sb0.pop_front();
        check("rsp0_z", 64'(bus.rsp0_z), 64'(e.z));
        check("rsp0_flags", 64'(bus.rsp0_flags), 64'(e.flags));
      end
    end
    if (bus.rsp1_valid && bus.rsp1_ready) begin
      if (sb1.size() == 0) check("rsp1_unexpected", 64'd1, 64'd0);
      else begin
        e = sb1.pop_front();
        check("rsp1_z", 64'(bus.rsp1_z), 64'(e.z));
        check("rsp1_flags", 64'(bus.rsp1_flags), 64'(e.flags));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic setReq(input int p, input logic v, input logic [31:0] a, input logic [31:0] b, input logic c);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_ctrl = c;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_ctrl = c;
    end
  endtask

  initial begin
    int n0;
    int n1;
    logic seen;
    logic expG;

    rst = 1'b1;
    setReq(0, 1'b1, 32'h1234_5678, 32'h1, 1'b0);
    setReq(1, 1'b1, 32'h8765_4321, 32'h2, 1'b1);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
`ifdef FPADD_ARB_STICKY_FLAGS_EN
    bus.sticky0_clr = 1'b0;
    bus.sticky1_clr = 1'b0;
`endif
    #2;
    check("rst_req0_ready", 64'(bus.req0_ready), 64'd0);
    check("rst_req1_ready", 64'(bus.req1_ready), 64'd0);
    check("rst_fp_valid", 64'(bus.fp_valid), 64'd0);
    check("rst_rsp0_valid", 64'(bus.rsp0_valid), 64'd0);
    check("rst_rsp1_valid", 64'(bus.rsp1_valid), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    setReq(0, 1'b0, 32'hDEAD_BEEF, 32'h5, 1'b1);
    setReq(1, 1'b0, 32'h0, 32'h0, 1'b0);
    settle();
    check("idle_fp_valid", 64'(bus.fp_valid), 64'd0);
    check("idle_fp_a", 64'(bus.fp_a), 64'd0);

    // Single op on port 0: 1.0 + 2.0, result PIPE_LAT+1 cycles after grant
    tick();
    setReq(0, 1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    settle();
    check("t038_ready", 64'(bus.req0_ready), 64'd1);
    check("t038_fp_valid", 64'(bus.fp_valid), 64'd1);
    check("t038_fp_a", 64'(bus.fp_a), 64'h3F80_0000);
    check("t038_fp_b", 64'(bus.fp_b), 64'h4000_0000);
    check("t038_fp_ctrl", 64'(bus.fp_ctrl), 64'd0);
    tick();
    setReq(0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick(); tick(); tick();
    settle();
    check("t038_early", 64'(bus.rsp0_valid), 64'd0);
    tick();
    settle();
    check("t038_valid", 64'(bus.rsp0_valid), 64'd1);
    check("t038_z", 64'(bus.rsp0_z), 64'h4040_0000);
    check("t038_flags", 64'(bus.rsp0_flags), 64'd0);
    bus.rsp0_ready = 1'b1;
    tick();
    bus.rsp0_ready = 1'b0;
    settle();
    check("t038_empty", 64'(bus.rsp0_valid), 64'd0);

    // Both contending, responses always consumed: strict alternation from port 0
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    expG = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      setReq(0, 1'b1, 32'h1000_0000 + 32'(i), 32'h0000_0100 * 32'(i), 1'b0);
      setReq(1, 1'b1, 32'h2000_0000 + 32'(i), 32'h0000_0011 * 32'(i), 1'(i));
      settle();
      check($sformatf("t039_g0_%0d", i), 64'(bus.req0_ready), 64'(!expG));
      check($sformatf("t039_g1_%0d", i), 64'(bus.req1_ready), 64'(expG));
      expG = ~expG;
    end
    tick();
    setReq(0, 1'b0, 32'h0, 32'h0, 1'b0);
    setReq(1, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (8) tick();
    check("t039_drain0", 64'(sb0.size()), 64'd0);
    check("t039_drain1", 64'(sb1.size()), 64'd0);

    // Port 1 responses stalled: it fills its credits then stays blocked.
    // Port 0 alone sustains FIFO_DEPTH issues per PIPE_LAT+2 cycles, since a
    // credit covers the op until the cycle after its result is consumed.
    bus.rsp1_ready = 1'b0;
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      setReq(0, 1'b1, 32'h3000_0000 + 32'(i), 32'h7, 1'b0);
      setReq(1, 1'b1, 32'h4000_0000 + 32'(i), 32'h3, 1'b1);
      settle();
      if (bus.req1_ready) n1++;
      if (i >= 12 && bus.req0_ready) n0++;
    end
    check("t040_port1_grants", 64'(n1), 64'(FIFO_DEPTH));
    check("t040_port0_window", 64'(n0), 64'd8);
    tick();
    setReq(0, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (8) tick();
    bus.rsp1_ready = 1'b1;
    settle();
    check("t040_blocked_on_pop", 64'(bus.req1_ready), 64'd0);
    check("t040_rsp1_valid", 64'(bus.rsp1_valid), 64'd1);
    tick();
    settle();
    check("t040_reenabled", 64'(bus.req1_ready), 64'd1);
    tick();
    setReq(1, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (12) tick();
    check("t040_drain0", 64'(sb0.size()), 64'd0);
    check("t040_drain1", 64'(sb1.size()), 64'd0);

    // FIFO 0 holding two entries takes a push and a pop in the same cycle
    bus.rsp0_ready = 1'b0;
    setReq(0, 1'b1, 32'h0000_0A00, 32'h1, 1'b0);
    settle();
    check("t043_grant", 64'(bus.req0_ready), 64'd1);
    tick();
    setReq(0, 1'b1, 32'h0000_0B00, 32'h2, 1'b0);
    tick();
    setReq(0, 1'b1, 32'h0000_0C00, 32'h3, 1'b0);
    tick();
    setReq(0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    settle();
    check("t043_one_held", 64'(bus.rsp0_valid), 64'd1);
    tick();
    bus.rsp0_ready = 1'b1;
    tick();
    bus.rsp0_ready = 1'b0;
    settle();
    check("t043_occupancy", 64'(dut.gPort[0].occQ), 64'd2);
    check("t043_head_b", 64'(bus.rsp0_z), 64'h0000_0B02);
    tick();
    bus.rsp0_ready = 1'b1;
    tick();
    settle();
    check("t043_head_c", 64'(bus.rsp0_z), 64'h0000_0C03);
    check("t043_valid_c", 64'(bus.rsp0_valid), 64'd1);
    tick();
    settle();
    check("t043_empty", 64'(bus.rsp0_valid), 64'd0);

    // Reset with three ops in flight: nothing comes back, credits cleared
    bus.rsp0_ready = 1'b0;
    tick();
    setReq(0, 1'b1, 32'h0000_5000, 32'h1, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    settle();
    check("t041_rst_ready", 64'(bus.req0_ready), 64'd0);
    check("t041_rst_fp_valid", 64'(bus.fp_valid), 64'd0);
    sb0.delete();
    sb1.delete();
    tick();
    rst = 1'b0;
    setReq(0, 1'b0, 32'h0, 32'h0, 1'b0);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    settle();
    check("t041_credit0", 64'(dut.gPort[0].creditQ), 64'd0);
    check("t041_credit1", 64'(dut.gPort[1].creditQ), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      settle();
      if (bus.rsp0_valid || bus.rsp1_valid) seen = 1'b1;
    end
    check("t041_no_rsp", 64'(seen), 64'd0);
    bus.rsp0_ready = 1'b0;
    n0 = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      setReq(0, 1'b1, 32'h0000_6000 + 32'(i), 32'h0, 1'b0);
      settle();
      if (bus.req0_ready) n0++;
    end
    check("t041_full_credit", 64'(n0), 64'(FIFO_DEPTH));
    tick();
    setReq(0, 1'b0, 32'h0, 32'h0, 1'b0);
    bus.rsp0_ready = 1'b1;
    repeat (10) tick();
    check("t041_drain0", 64'(sb0.size()), 64'd0);

`ifdef FPADD_ARB_STICKY_FLAGS_EN
    // Sticky flags: accumulate, then clear coinciding with a write
    bus.sticky0_clr = 1'b1;
    tick();
    bus.sticky0_clr = 1'b0;
    settle();
    check("t042_cleared", 64'(bus.sticky0_flags), 64'd0);
    setReq(0, 1'b1, 32'h0000_0011, 32'h0, 1'b0);
    tick();
    setReq(0, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (4) tick();
    settle();
    check("t042_first", 64'(bus.sticky0_flags), 64'h11);
    setReq(0, 1'b1, 32'h0000_0001, 32'h0, 1'b0);
    tick();
    setReq(0, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (3) tick();
    bus.sticky0_clr = 1'b1;
    tick();
    bus.sticky0_clr = 1'b0;
    settle();
    check("t042_clr_with_write", 64'(bus.sticky0_flags), 64'h01);
    check("t042_other_port", 64'(bus.sticky1_flags), 64'(dut.gPort[1].stickyQ));
    repeat (4) tick();
`endif

    check("final_sb0", 64'(sb0.size()), 64'd0);
    check("final_sb1", 64'(sb1.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
